// File: rtl/draw_pkg.sv
// Shared definitions for the draw sequencer: state encoding, default widths
// and the idle/blanking command code helper.
package draw_pkg;

    localparam int DEF_NUM_CMDS = 15;
    localparam int DEF_CMD_W    = 4;
    localparam int DEF_WAIT_W   = 17;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

    // All-ones code of the given width, used as the default non-draw command
    function automatic logic [31:0] blank_code(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/draw_sequencer_if.sv
// Command handshake between the sequencer (master) and the downstream drawer.
interface draw_sequencer_if
    import draw_pkg::*;
#(
    parameter int CMD_W = DEF_CMD_W
);

    logic [CMD_W-1:0] cmd;
    logic             cmd_valid;
    logic             cmd_ready;

    modport master (
        output cmd,
        output cmd_valid,
        input  cmd_ready
    );

    modport slave (
        input  cmd,
        input  cmd_valid,
        output cmd_ready
    );

endinterface

// File: rtl/draw_sequencer_blank_timer.sv
// Blanking interval timer: load clears the count and captures the wait value,
// tc flags that the count has reached the captured value.
module blank_timer
    import draw_pkg::*;
#(
    parameter int WAIT_W = DEF_WAIT_W
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              load,
    input  logic              count,
    input  logic [WAIT_W-1:0] wait_value,
    output logic              tc
);

    logic [WAIT_W-1:0] count_r;
    logic [WAIT_W-1:0] wait_r;

    // Count register and captured blanking length
    always_ff @(posedge CLK) begin
        if (!reset) begin
            count_r <= {WAIT_W{1'b0}};
            wait_r  <= {WAIT_W{1'b0}};
        end else if (load) begin
            count_r <= {WAIT_W{1'b0}};
            wait_r  <= wait_value;
        end else if (count) begin
            count_r <= count_r + {{(WAIT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign tc = (count_r == wait_r);

endmodule

// File: rtl/draw_sequencer.sv
// Frame sequencer: issues NUM_CMDS draw commands per frame over a valid/ready
// handshake, then holds a programmable blanking interval before the next frame.
module draw_sequencer
    import draw_pkg::*;
#(
    parameter int               NUM_CMDS  = DEF_NUM_CMDS,
    parameter int               CMD_W     = DEF_CMD_W,
    parameter int               WAIT_W    = DEF_WAIT_W,
    parameter logic [CMD_W-1:0] BLANK_CMD = CMD_W'(blank_code(CMD_W))
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [WAIT_W-1:0]       wait_cycles,
    draw_sequencer_if.master        cmd_bus,
    output logic                    frame_start,
    output logic                    busy,
    output logic [7:0]              frame_count
);

    localparam logic [CMD_W-1:0] LAST_IDX = CMD_W'(NUM_CMDS - 1);

    state_t           state_r;
    state_t           state_s;
    logic [CMD_W-1:0] index_r;
    logic [CMD_W-1:0] index_s;
    logic [7:0]       frame_count_r;
    logic [7:0]       frame_count_s;
    logic [CMD_W-1:0] cmd_r;
    logic [CMD_W-1:0] cmd_s;
    logic             valid_r;
    logic             valid_s;
    logic             start_r;
    logic             start_s;
    logic             busy_r;
    logic             busy_s;
    logic             load_s;
    logic             count_s;
    logic             tc_s;

    blank_timer #(
        .WAIT_W (WAIT_W)
    ) u_blank_timer (
        .CLK        (CLK),
        .reset      (reset),
        .load       (load_s),
        .count      (count_s),
        .wait_value (wait_cycles),
        .tc         (tc_s)
    );

    // Next-state, index and frame counter decisions, plus next output values
    always_comb begin
        state_s       = ST_IDLE;
        index_s       = index_r;
        frame_count_s = frame_count_r;
        load_s        = 1'b0;
        count_s       = 1'b0;
        cmd_s         = BLANK_CMD;
        valid_s       = 1'b0;
        busy_s        = 1'b0;
        start_s       = 1'b0;

        case (state_r)
            ST_IDLE: begin
                index_s = {CMD_W{1'b0}};
                if (enable) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_s = ST_ISSUE;
                if (cmd_bus.cmd_ready) begin
                    if (index_r == LAST_IDX) begin
                        state_s       = ST_BLANK;
                        index_s       = {CMD_W{1'b0}};
                        load_s        = 1'b1;
                        frame_count_s = frame_count_r + 8'd1;
                    end else begin
                        index_s = index_r + {{(CMD_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    index_s = index_r;
                end
            end
            ST_BLANK: begin
                count_s = 1'b1;
                index_s = {CMD_W{1'b0}};
                if (tc_s) begin
                    if (enable) begin
                        state_s = ST_ISSUE;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_BLANK;
                end
            end
            default: begin
                state_s = ST_IDLE;
                index_s = {CMD_W{1'b0}};
            end
        endcase

        // Outputs are decoded from the next state so they can be registered
        case (state_s)
            ST_ISSUE: begin
                cmd_s   = index_s;
                valid_s = 1'b1;
                busy_s  = 1'b1;
            end
            ST_BLANK: begin
                cmd_s   = BLANK_CMD;
                valid_s = 1'b0;
                busy_s  = 1'b1;
            end
            default: begin
                cmd_s   = BLANK_CMD;
                valid_s = 1'b0;
                busy_s  = 1'b0;
            end
        endcase

        if ((state_s == ST_ISSUE) && (state_r != ST_ISSUE)) begin
            start_s = 1'b1;
        end else begin
            start_s = 1'b0;
        end
    end

    // State, index, frame counter and registered outputs
    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            index_r       <= {CMD_W{1'b0}};
            frame_count_r <= 8'd0;
            cmd_r         <= BLANK_CMD;
            valid_r       <= 1'b0;
            start_r       <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            index_r       <= index_s;
            frame_count_r <= frame_count_s;
            cmd_r         <= cmd_s;
            valid_r       <= valid_s;
            start_r       <= start_s;
            busy_r        <= busy_s;
        end
    end

    assign cmd_bus.cmd       = cmd_r;
    assign cmd_bus.cmd_valid = valid_r;
    assign frame_start       = start_r;
    assign busy              = busy_r;
    assign frame_count       = frame_count_r;

endmodule

// File: tb/tb_draw_sequencer.sv
// Self-checking bench: directed scenarios plus randomized traffic on two
// configurations, compared each cycle against a frame-position reference model.
module tb_draw_sequencer;

    typedef struct {
        bit run;
        int pos;
        int wt;
        int fc;
        bit start;
    } model_t;

    logic        CLK = 1'b0;
    logic        reset_a;
    logic        enable_a;
    logic [16:0] wait_a;
    logic        start_a;
    logic        busy_a;
    logic [7:0]  fc_a;
    logic        reset_b;
    logic        enable_b;
    logic [16:0] wait_b;
    logic        start_b;
    logic        busy_b;
    logic [7:0]  fc_b;
    bit          chk_on = 1'b0;
    int          checks = 0;
    int          errors = 0;
    model_t      ma = '{1'b0, 0, 0, 0, 1'b0};
    model_t      mb = '{1'b0, 0, 0, 0, 1'b0};

    draw_sequencer_if #(.CMD_W(4)) bus_a ();
    draw_sequencer_if #(.CMD_W(2)) bus_b ();

    draw_sequencer #(.NUM_CMDS(15), .CMD_W(4), .WAIT_W(17)) dut_a (
        .CLK         (CLK),
        .reset       (reset_a),
        .enable      (enable_a),
        .wait_cycles (wait_a),
        .cmd_bus     (bus_a),
        .frame_start (start_a),
        .busy        (busy_a),
        .frame_count (fc_a)
    );

    draw_sequencer #(.NUM_CMDS(1), .CMD_W(2), .WAIT_W(17)) dut_b (
        .CLK         (CLK),
        .reset       (reset_b),
        .enable      (enable_b),
        .wait_cycles (wait_b),
        .cmd_bus     (bus_b),
        .frame_start (start_b),
        .busy        (busy_b),
        .frame_count (fc_b)
    );

    logic [31:0] cmd_a32;
    logic [31:0] cmd_b32;
    logic [31:0] fc_a32;
    logic [31:0] fc_b32;
    assign cmd_a32 = {28'd0, bus_a.cmd};
    assign cmd_b32 = {30'd0, bus_b.cmd};
    assign fc_a32  = {24'd0, fc_a};
    assign fc_b32  = {24'd0, fc_b};

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Frame position model: pos < n is issuing command pos, pos >= n is blanking
    function automatic model_t step(input model_t m, input logic rst, input logic en,
                                    input logic rdy, input int wt, input int n);
        model_t r = m;
        r.start = 1'b0;
        if (!rst) begin
            r.run = 1'b0; r.pos = 0; r.wt = 0; r.fc = 0;
        end else if (!m.run) begin
            if (en) begin
                r.run = 1'b1; r.pos = 0; r.start = 1'b1;
            end
        end else if (m.pos < n) begin
            if (rdy) begin
                r.pos = m.pos + 1;
                if (m.pos == n - 1) begin
                    r.wt = wt;
                    r.fc = (m.fc + 1) % 256;
                end
            end
        end else if (m.pos - n == m.wt) begin
            if (en) begin
                r.pos = 0; r.start = 1'b1;
            end else begin
                r.run = 1'b0;
            end
        end else begin
            r.pos = m.pos + 1;
        end
        return r;
    endfunction

    task automatic cmp(input string tag, input logic [31:0] cmd, input logic valid,
                       input logic start, input logic busy, input logic [31:0] fc,
                       input model_t m, input int n, input int blank);
        logic issuing;
        issuing = m.run && (m.pos < n);
        check({tag, "_cmd"}, cmd, issuing ? m.pos : blank);
        check_bit({tag, "_valid"}, valid, issuing);
        check_bit({tag, "_start"}, start, m.start);
        check_bit({tag, "_busy"}, busy, m.run);
        check({tag, "_fc"}, fc, m.fc);
    endtask

    always @(posedge CLK) begin
        ma <= step(ma, reset_a, enable_a, bus_a.cmd_ready, int'(wait_a), 15);
        mb <= step(mb, reset_b, enable_b, bus_b.cmd_ready, int'(wait_b), 1);
    end

    always @(negedge CLK) begin
        if (chk_on) begin
            cmp("a", cmd_a32, bus_a.cmd_valid, start_a, busy_a, fc_a32, ma, 15, 15);
            cmp("b", cmd_b32, bus_b.cmd_valid, start_b, busy_b, fc_b32, mb, 1, 3);
        end
    end

    task automatic wait_cmd_a(input int val, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (cmd_a32 == val) break;
        end
        check("wait_cmd", cmd_a32, val);
    endtask

    initial begin
        int p;
        int n;
        int blanks;
        reset_a = 1'b0; enable_a = 1'b0; bus_a.cmd_ready = 1'b1; wait_a = 17'd3;
        reset_b = 1'b0; enable_b = 1'b0; bus_b.cmd_ready = 1'b1; wait_b = 17'd2;
        repeat (3) @(negedge CLK);
        chk_on = 1'b1;

        check("rst_cmd", cmd_a32, 32'd15);
        check_bit("rst_valid", bus_a.cmd_valid, 1'b0);
        check_bit("rst_busy", busy_a, 1'b0);
        check_bit("rst_start", start_a, 1'b0);
        check("rst_fc", fc_a32, 32'd0);

        // Free-running frames: 15 commands then 4 blanking cycles
        reset_a = 1'b1; enable_a = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            p = k % 19;
            check("seq_cmd", cmd_a32, (p < 15) ? p : 15);
            check_bit("seq_start", start_a, p == 0);
            check("seq_fc", fc_a32, (k + 4) / 19);
            if (k == 15) check("model_fc", ma.fc, 32'd1);
            if (k == 19) check_bit("model_start", ma.start, 1'b1);
        end

        // Backpressure at command 5
        wait_cmd_a(5, 40);
        bus_a.cmd_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            check("bp_hold_cmd", cmd_a32, 32'd5);
            check_bit("bp_hold_valid", bus_a.cmd_valid, 1'b1);
        end
        bus_a.cmd_ready = 1'b1;
        @(negedge CLK);
        check("bp_advance", cmd_a32, 32'd6);

        // Zero-length wait: single blanking cycle, 16-cycle period
        wait_a = 17'd0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (start_a) break;
        end
        check_bit("w0_first_start", start_a, 1'b1);
        n = 0; blanks = 0;
        do begin
            @(negedge CLK);
            n++;
            if (!bus_a.cmd_valid) blanks++;
        end while (!start_a && n < 40);
        check("w0_period", n, 32'd16);
        check("w0_blanks", blanks, 32'd1);

        // Enable dropped at command 7: frame and blanking still complete
        wait_a = 17'd3;
        wait_cmd_a(7, 40);
        enable_a = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge CLK);
            if (k < 7) begin
                check("drop_cmd", cmd_a32, 8 + k);
                check_bit("drop_valid", bus_a.cmd_valid, 1'b1);
            end else if (k < 11) begin
                check("drop_blank_cmd", cmd_a32, 32'd15);
                check_bit("drop_blank_busy", busy_a, 1'b1);
            end else begin
                check_bit("drop_idle_busy", busy_a, 1'b0);
                check_bit("drop_idle_start", start_a, 1'b0);
                check_bit("drop_idle_valid", bus_a.cmd_valid, 1'b0);
            end
        end

        // Restart from idle, then reset in mid-frame
        enable_a = 1'b1;
        @(negedge CLK);
        check("restart_cmd", cmd_a32, 32'd0);
        check_bit("restart_start", start_a, 1'b1);
        wait_cmd_a(10, 40);
        reset_a = 1'b0;
        @(negedge CLK);
        check("mid_rst_cmd", cmd_a32, 32'd15);
        check_bit("mid_rst_valid", bus_a.cmd_valid, 1'b0);
        check("mid_rst_fc", fc_a32, 32'd0);
        reset_a = 1'b1;
        @(negedge CLK);
        check("post_rst_cmd", cmd_a32, 32'd0);
        check_bit("post_rst_start", start_a, 1'b1);

        // Randomized traffic on the default configuration
        for (int k = 0; k < 2000; k++) begin
            @(negedge CLK);
            bus_a.cmd_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 49) == 0) enable_a = ~enable_a;
            if ($urandom_range(0, 7) == 0) wait_a = 17'($urandom_range(0, 5));
            reset_a = ($urandom_range(0, 299) != 0);
        end

        // Single-command configuration: 0,3,3,3 repeating
        @(negedge CLK);
        reset_b = 1'b1; enable_b = 1'b1; bus_b.cmd_ready = 1'b1; wait_b = 17'd2;
        for (int k = 0; k < 12; k++) begin
            @(negedge CLK);
            check("one_cmd", cmd_b32, ((k % 4) == 0) ? 0 : 3);
            check_bit("one_start", start_b, (k % 4) == 0);
        end
        for (int k = 0; k < 600; k++) begin
            @(negedge CLK);
            bus_b.cmd_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 29) == 0) enable_b = ~enable_b;
            if ($urandom_range(0, 5) == 0) wait_b = 17'($urandom_range(0, 3));
            reset_b = ($urandom_range(0, 199) != 0);
        end

        @(negedge CLK);
        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
